// File: rtl/prng_seq_ctrl.sv
// Sequencer for an external 8-bit PRNG core: seed load, warm-up stepping, then
// on-demand or free-running sample capture with a valid/ready output.
module prng_seq_ctrl #(
  parameter int unsigned CLK_HZ  = 10_000_000,
  parameter int unsigned STEP_HZ = 1_000,
  parameter int unsigned WARMUP  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       seed_load,
  input  logic [7:0] seed,
  input  logic       mode,
  input  logic       req,
  output logic       prng_load,
  output logic [7:0] prng_seed,
  output logic       prng_step,
  input  logic [7:0] prng_q,
  output logic       smp_valid,
  output logic [7:0] smp_data,
  input  logic       smp_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned DIV  = CLK_HZ / STEP_HZ;
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [7:0] WarmInit = 8'(WARMUP);

  typedef enum logic [2:0] {StLoad, StWarm, StRun, StStep, StCapt} state_e;

  state_e          state_q, state_d;
  logic [7:0]      warm_q, warm_d;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      seed_q, seed_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      warm_q  <= '0;
      div_q   <= '0;
      seed_q  <= 8'h01;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      div_q   <= div_d;
      seed_q  <= seed_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    div_d   = div_q;
    seed_d  = seed_q;
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (ena) begin
      if (seed_load) begin
        // An all-zero seed would lock up an LFSR core, so substitute 1.
        seed_d  = (seed == 8'h00) ? 8'h01 : seed;
        valid_d = 1'b0;
        ovr_d   = 1'b0;
        div_d   = '0;
        warm_d  = '0;
        state_d = StLoad;
      end else begin
        if (valid_q && smp_ready) valid_d = 1'b0;
        div_d = '0;
        case (state_q)
          StLoad: begin
            warm_d  = WarmInit;
            state_d = StWarm;
          end
          StWarm: begin
            if (warm_q <= 8'd1) begin
              warm_d  = '0;
              state_d = StRun;
            end else begin
              warm_d = warm_q - 8'd1;
            end
          end
          StRun: begin
            if (mode) begin
              if (div_q == DivLast) state_d = StStep;
              else div_d = div_q + 1'b1;
            end else if (req && !valid_q) begin
              state_d = StStep;
            end
          end
          StStep: state_d = StCapt;
          StCapt: begin
            // New sample wins over a same-edge transfer; overrun only if it was not taken.
            data_d  = prng_q;
            valid_d = 1'b1;
            if (valid_q && !smp_ready) ovr_d = 1'b1;
            state_d = StRun;
          end
          default: state_d = StLoad;
        endcase
      end
    end
  end

  // Commands are gated by rst_n so they are quiet while reset is asserted.
  assign prng_load = rst_n && ena && (state_q == StLoad);
  assign prng_step = rst_n && ena && ((state_q == StWarm) || (state_q == StStep));
  assign prng_seed = seed_q;
  assign smp_valid = valid_q;
  assign smp_data  = data_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StRun);

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Bench for prng_seq_ctrl: behavioural LFSR core, vector table for the basic flow,
// hand-written sequences for enable freeze, free-run, reseed and async reset.
module tb_prng_seq_ctrl;

  localparam int unsigned CLK_HZ  = 10_000_000;
  localparam int unsigned STEP_HZ = 1_000_000;
  localparam int unsigned WARMUP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       mode = 1'b0;
  logic       req = 1'b0;
  logic       smp_ready = 1'b0;
  logic       prng_load, prng_step, smp_valid, busy, overrun;
  logic [7:0] prng_seed, prng_q, smp_data;

  int errors = 0;
  int checks = 0;

  prng_seq_ctrl #(
    .CLK_HZ (CLK_HZ),
    .STEP_HZ(STEP_HZ),
    .WARMUP (WARMUP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .seed_load(seed_load),
    .seed     (seed),
    .mode     (mode),
    .req      (req),
    .prng_load(prng_load),
    .prng_seed(prng_seed),
    .prng_step(prng_step),
    .prng_q   (prng_q),
    .smp_valid(smp_valid),
    .smp_data (smp_data),
    .smp_ready(smp_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] lfsr_n(input logic [7:0] q, input int n);
    logic [7:0] r;
    r = q;
    for (int i = 0; i < n; i++) r = lfsr(r);
    return r;
  endfunction

  // Behavioural PRNG core driven by the DUT's commands.
  logic [7:0] core_q = 8'h00;
  assign prng_q = core_q;
  always @(posedge clk) begin
    if (prng_load) core_q <= prng_seed;
    else if (prng_step) core_q <= lfsr(core_q);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ena, sl;
    logic [7:0] seed;
    logic       mode, req, rdy;
    logic       e_load, e_step, e_valid, e_busy, e_ovr;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic sl, input logic [7:0] sd,
                              input logic md, input logic rq, input logic rd,
                              input logic ld, input logic st, input logic vl,
                              input logic bs, input logic ov);
    vec_t v;
    v.ena = en; v.sl = sl; v.seed = sd; v.mode = md; v.req = rq; v.rdy = rd;
    v.e_load = ld; v.e_step = st; v.e_valid = vl; v.e_busy = bs; v.e_ovr = ov;
    v.chk_data = 1'b0; v.e_data = 8'h00;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_cmds(input int n, output int loads, output int steps);
    loads = 0;
    steps = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      loads += int'(prng_load);
      steps += int'(prng_step);
      tick();
    end
  endtask

  vec_t vecs[15];
  int   nl, ns, found;
  int   pos[3];

  initial begin
    vecs[0] = mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) vecs[i] = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[5]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[8]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
    vecs[10] = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
    vecs[11] = mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0);
    vecs[12] = mk(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[14] = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    // Seed 01, 4 warm-up steps plus 1 sample step.
    vecs[9].chk_data  = 1'b1; vecs[9].e_data  = lfsr_n(8'h01, 5);
    vecs[11].chk_data = 1'b1; vecs[11].e_data = lfsr_n(8'h01, 5);

    // Reset held with ena high: commands must stay quiet.
    ena = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_load", prng_load, 0);
    chk("rst_step", prng_step, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 8'h00);
    chk("rst_seed", prng_seed, 8'h01);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      ena = vecs[i].ena; seed_load = vecs[i].sl; seed = vecs[i].seed;
      mode = vecs[i].mode; req = vecs[i].req; smp_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_load", i), prng_load, vecs[i].e_load);
      chk($sformatf("v%0d_step", i), prng_step, vecs[i].e_step);
      chk($sformatf("v%0d_valid", i), smp_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_ovr", i), overrun, vecs[i].e_ovr);
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), smp_data, vecs[i].e_data);
      if (i == 13) chk("v13_seed_zero_sub", prng_seed, 8'h01);
      tick();
    end
    seed_load = 1'b0; req = 1'b0; smp_ready = 1'b0;

    // Freeze mid-warm-up for 20 cycles; a seed_load in that window is ignored.
    ena = 1'b0;
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      seed_load = (i == 5);
      seed = 8'h77;
      #1;
      ns += int'(prng_step);
      tick();
    end
    seed_load = 1'b0;
    #1;
    chk("frz_steps", 8'(ns), 0);
    chk("frz_seed", prng_seed, 8'h01);
    chk("frz_busy", busy, 1);
    ena = 1'b1;
    count_cmds(8, nl, ns);
    chk("frz_resume_steps", 8'(ns), 3);
    chk("frz_resume_loads", 8'(nl), 0);
    #1;
    chk("frz_done_busy", busy, 0);

    // Free-run with the consumer always ready: one step every 12 cycles.
    mode = 1'b1;
    smp_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 60 && found < 3; c++) begin
      #1;
      if (prng_step) begin
        pos[found] = c;
        found++;
      end
      if (found < 3) tick();
    end
    chk("fr_pulses", 8'(found), 3);
    if (found == 3) begin
      chk("fr_period1", 8'(pos[1] - pos[0]), 12);
      chk("fr_period2", 8'(pos[2] - pos[1]), 12);
    end
    chk("fr_ovr_ready", overrun, 0);
    // Consumer stalls: first capture is fine, second sets overrun.
    smp_ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("fr_first_valid", smp_valid, 1);
    chk("fr_first_ovr", overrun, 0);
    repeat (15) tick();
    #1;
    chk("fr_second_ovr", overrun, 1);
    chk("fr_second_valid", smp_valid, 1);

    // Reseed with zero while a sample is pending.
    mode = 1'b0;
    seed_load = 1'b1;
    seed = 8'h00;
    tick();
    seed_load = 1'b0;
    #1;
    chk("rs_valid", smp_valid, 0);
    chk("rs_seed", prng_seed, 8'h01);
    chk("rs_ovr", overrun, 0);
    count_cmds(10, nl, ns);
    chk("rs_loads", 8'(nl), 1);
    chk("rs_steps", 8'(ns), 4);
    #1;
    chk("rs_busy", busy, 0);

    // Nonzero seed, on-demand sample, then async reset during CAPT.
    seed_load = 1'b1;
    seed = 8'hA5;
    tick();
    seed_load = 1'b0;
    #1;
    chk("a5_seed", prng_seed, 8'hA5);
    count_cmds(6, nl, ns);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    #1;
    chk("a5_valid", smp_valid, 1);
    chk("a5_data", smp_data, lfsr_n(8'hA5, 5));
    smp_ready = 1'b1;
    tick();
    smp_ready = 1'b0;
    #1;
    chk("a5_taken", smp_valid, 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_load", prng_load, 0);
    chk("ar_step", prng_step, 0);
    chk("ar_valid", smp_valid, 0);
    chk("ar_data", smp_data, 8'h00);
    chk("ar_seed", prng_seed, 8'h01);
    chk("ar_ovr", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_first_load", prng_load, 1);
    tick();
    #1;
    chk("ar_first_step", prng_step, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
